// File: rtl/sfx_pkg.sv
// Shared types and helpers for the multi-voice sound-effect player.
package sfx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      ACC,
      PRESENT
   } sfx_state_t;

   localparam int SFX_CLK_DIV_DEFAULT = 6250;

   // Clamp a wide signed value into the range of a w-bit signed number.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                     input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi)
         return hi;
      else if (x < lo)
         return lo;
      else
         return x;
   endfunction

endpackage

// File: rtl/sfx_voice.sv
// One playback voice: clip position and busy flag with trigger > stop > advance priority.
// Looping on wrap is available when SFX_LOOP_EN is defined.
module sfx_voice #(
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              trigger,
   input  logic              stop,
   input  logic              advance,
   input  logic [ADDR_W-1:0] len,
`ifdef SFX_LOOP_EN
   input  logic              loop_en,
`endif
   output logic [ADDR_W-1:0] pos,
   output logic              busy
);

   logic keep_on_wrap;

`ifdef SFX_LOOP_EN
   assign keep_on_wrap = loop_en;
`else
   assign keep_on_wrap = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos  <= '0;
         busy <= 1'b0;
      end else if (trigger && (len != '0)) begin
         pos  <= '0;
         busy <= 1'b1;
      end else if (stop) begin
         busy <= 1'b0;
      end else if (advance && busy) begin
         if (pos == len - 1'b1) begin
            pos  <= '0;
            busy <= keep_on_wrap;
         end else begin
            pos <= pos + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sfx_player.sv
// Multi-voice sound-effect player: tick divider, voice-serial ROM fetch, saturating mix,
// valid/ready sample output. Optional per-voice looping via the SFX_LOOP_EN macro.
module sfx_player
   import sfx_pkg::*;
#(
   parameter int NUM_VOICES = 2,
   parameter int SAMPLE_W   = 16,
   parameter int ADDR_W     = 15,
   parameter int OUT_W      = 32,
   parameter int CLK_DIV    = SFX_CLK_DIV_DEFAULT
) (
   input  logic                         CLOCK_50,
   input  logic                         KEY,
   input  logic [NUM_VOICES-1:0]        trigger,
   input  logic [NUM_VOICES-1:0]        stop,
   input  logic [NUM_VOICES*ADDR_W-1:0] voice_base,
   input  logic [NUM_VOICES*ADDR_W-1:0] voice_len,
`ifdef SFX_LOOP_EN
   input  logic [NUM_VOICES-1:0]        loop_en,
`endif
   output logic [ADDR_W-1:0]            rom_addr,
   input  logic [SAMPLE_W-1:0]          rom_q,
   output logic [OUT_W-1:0]             sample_out,
   output logic                         sample_valid,
   input  logic                         sample_ready,
   output logic [NUM_VOICES-1:0]        busy,
   output logic                         overrun
);

   localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int AW = SAMPLE_W + $clog2(NUM_VOICES) + 1;
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0]          tick_cnt;
   logic                   tick;
   sfx_state_t             state;
   logic [VW-1:0]          v;
   logic signed [AW-1:0]   acc;
   logic signed [AW-1:0]   contrib;
   logic signed [AW-1:0]   acc_sum;
   logic signed [63:0]     sat_wide;
   logic [ADDR_W-1:0]      base_a [NUM_VOICES];
   logic [ADDR_W-1:0]      len_a  [NUM_VOICES];
   logic [ADDR_W-1:0]      pos_a  [NUM_VOICES];
   logic [NUM_VOICES-1:0]  adv;

   assign tick = (tick_cnt == CW'(CLK_DIV - 1));

   for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
      assign base_a[i] = voice_base[i*ADDR_W +: ADDR_W];
      assign len_a[i]  = voice_len[i*ADDR_W +: ADDR_W];
      assign adv[i]    = (state == ACC) && (v == VW'(i));

      sfx_voice #(
         .ADDR_W(ADDR_W)
      ) u_voice (
         .clk     (CLOCK_50),
         .rst_n   (KEY),
         .trigger (trigger[i]),
         .stop    (stop[i]),
         .advance (adv[i]),
         .len     (len_a[i]),
`ifdef SFX_LOOP_EN
         .loop_en (loop_en[i]),
`endif
         .pos     (pos_a[i]),
         .busy    (busy[i])
      );
   end

   always_comb begin
      contrib = '0;
      if (busy[v])
         contrib = AW'($signed(rom_q));
      acc_sum  = acc + contrib;
      sat_wide = sat_signed(acc_sum, SAMPLE_W);
   end

   always_ff @(posedge CLOCK_50 or negedge KEY) begin
      if (!KEY) begin
         tick_cnt     <= '0;
         state        <= IDLE;
         v            <= '0;
         acc          <= '0;
         rom_addr     <= '0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         if (tick && (state != IDLE))
            overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (tick) begin
                  acc   <= '0;
                  v     <= '0;
                  state <= READ;
               end
            end
            READ: begin
               rom_addr <= base_a[v] + pos_a[v];
               state    <= ACC;
            end
            ACC: begin
               acc <= acc_sum;
               if (v != VW'(NUM_VOICES - 1)) begin
                  v     <= v + 1'b1;
                  state <= READ;
               end else begin
                  // Final voice is folded in here so the sample is registered on PRESENT entry.
                  sample_out   <= OUT_W'(sat_wide[SAMPLE_W-1:0]) << (OUT_W - SAMPLE_W);
                  sample_valid <= 1'b1;
                  state        <= PRESENT;
               end
            end
            PRESENT: begin
               if (sample_ready) begin
                  sample_valid <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sfx_player.sv
// Directed bench for sfx_player with CLK_DIV=16, two voices and a behavioural ROM.
module tb_sfx_player;

   localparam int NV  = 2;
   localparam int SW  = 16;
   localparam int AW  = 15;
   localparam int OW  = 32;
   localparam int DIV = 16;

   logic             CLOCK_50 = 1'b0;
   logic             KEY = 1'b0;
   logic [NV-1:0]    trigger = '0;
   logic [NV-1:0]    stop = '0;
   logic [NV*AW-1:0] voice_base = '0;
   logic [NV*AW-1:0] voice_len = '0;
`ifdef SFX_LOOP_EN
   logic [NV-1:0]    loop_en = '0;
`endif
   logic [AW-1:0]    rom_addr;
   logic [SW-1:0]    rom_q;
   logic [OW-1:0]    sample_out;
   logic             sample_valid;
   logic             sample_ready = 1'b1;
   logic [NV-1:0]    busy;
   logic             overrun;

   logic [SW-1:0]    rom [0:(1<<AW)-1];

   int checks = 0;
   int errors = 0;

   always #10 CLOCK_50 = ~CLOCK_50;

   assign rom_q = rom[rom_addr];

   sfx_player #(
      .NUM_VOICES (NV),
      .SAMPLE_W   (SW),
      .ADDR_W     (AW),
      .OUT_W      (OW),
      .CLK_DIV    (DIV)
   ) dut (
      .CLOCK_50     (CLOCK_50),
      .KEY          (KEY),
      .trigger      (trigger),
      .stop         (stop),
      .voice_base   (voice_base),
      .voice_len    (voice_len),
`ifdef SFX_LOOP_EN
      .loop_en      (loop_en),
`endif
      .rom_addr     (rom_addr),
      .rom_q        (rom_q),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .busy         (busy),
      .overrun      (overrun)
   );

   typedef struct {
      logic [NV-1:0] trig;
      int            b0;
      int            l0;
      int            b1;
      int            l1;
      logic [31:0]   exp_s;
      logic [NV-1:0] exp_b;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_voice(input int vi, input int base, input int len);
      voice_base[vi*AW +: AW] = AW'(base);
      voice_len[vi*AW +: AW]  = AW'(len);
   endtask

   task automatic pulse(input logic [NV-1:0] t, input logic [NV-1:0] s);
      trigger = t;
      stop    = s;
      @(negedge CLOCK_50);
      trigger = '0;
      stop    = '0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (sample_valid !== 1'b1 && cyc < 200) begin
         @(negedge CLOCK_50);
         cyc++;
      end
      if (sample_valid !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL sample_timeout: sample_valid still low after %0d cycles", cyc);
      end
   endtask

   task automatic wait_sample(output logic [31:0] s, output logic [NV-1:0] b, output int cyc);
      wait_valid(cyc);
      s = sample_out;
      b = busy;
      @(negedge CLOCK_50);
   endtask

   initial begin
      logic [31:0]   s;
      logic [NV-1:0] b;
      int            cyc;
      int            bad;

      for (int i = 0; i < (1 << AW); i++) rom[i] = '0;
      rom[100] = 16'd10;  rom[101] = 16'd20;  rom[102] = 16'd30;
      rom[103] = 16'hFFFB; rom[104] = 16'd7;
      rom[200] = 16'h7000; rom[300] = 16'h9000;
      rom[400] = 16'd5;   rom[401] = 16'd6;

      vecs[0] = '{2'b01, 100, 3, 200, 1, 32'h000A0000, 2'b01};
      vecs[1] = '{2'b00, 100, 3, 200, 1, 32'h00140000, 2'b01};
      vecs[2] = '{2'b00, 100, 3, 200, 1, 32'h001E0000, 2'b00};
      vecs[3] = '{2'b00, 100, 3, 200, 1, 32'h00000000, 2'b00};
      vecs[4] = '{2'b11, 200, 1, 200, 1, 32'h7FFF0000, 2'b00};
      vecs[5] = '{2'b11, 300, 1, 300, 1, 32'h80000000, 2'b00};
      vecs[6] = '{2'b11, 100, 3, 103, 2, 32'h00050000, 2'b11};
      vecs[7] = '{2'b00, 100, 3, 103, 2, 32'h001B0000, 2'b01};
      vecs[8] = '{2'b00, 100, 3, 103, 2, 32'h001E0000, 2'b00};
      vecs[9] = '{2'b01, 100, 0, 103, 2, 32'h00000000, 2'b00};

      // Reset state
      repeat (3) @(negedge CLOCK_50);
      chk("rst_sample_out", sample_out, 32'h0);
      chk("rst_valid", 32'(sample_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_overrun", 32'(overrun), 32'h0);
      chk("rst_rom_addr", 32'(rom_addr), 32'h0);

      // First tick lands after DIV cycles; valid follows 5 cycles later
      KEY = 1'b1;
      wait_sample(s, b, cyc);
      chk("first_latency", 32'(cyc), 32'd20);
      chk("idle_sample0", s, 32'h0);
      wait_sample(s, b, cyc);
      chk("idle_period", 32'(cyc), 32'd15);
      chk("idle_sample1", s, 32'h0);
      chk("idle_busy", 32'(b), 32'h0);

      for (int i = 0; i < 10; i++) begin
         set_voice(0, vecs[i].b0, vecs[i].l0);
         set_voice(1, vecs[i].b1, vecs[i].l1);
         if (vecs[i].trig != '0)
            pulse(vecs[i].trig, '0);
         wait_sample(s, b, cyc);
         chk($sformatf("vec%0d_sample", i), s, vecs[i].exp_s);
         chk($sformatf("vec%0d_busy", i), 32'(b), 32'(vecs[i].exp_b));
      end
      chk("no_overrun_yet", 32'(overrun), 32'h0);

      // Backpressure: held sample, dropped ticks, resume after accept
      set_voice(0, 100, 3);
      pulse(2'b01, '0);
      sample_ready = 1'b0;
      wait_valid(cyc);
      s = sample_out;
      chk("hold_first", s, 32'h000A0000);
      bad = 0;
      repeat (40) begin
         @(negedge CLOCK_50);
         if (sample_out !== s || sample_valid !== 1'b1) bad++;
      end
      chk("hold_stable", 32'(bad), 32'h0);
      chk("overrun_set", 32'(overrun), 32'h1);
      sample_ready = 1'b1;
      @(negedge CLOCK_50);
      chk("valid_falls", 32'(sample_valid), 32'h0);
      wait_sample(s, b, cyc);
      chk("after_accept_sample", s, 32'h00140000);
      chk("after_accept_soon", 32'(cyc <= 21), 32'h1);
      wait_sample(s, b, cyc);
      chk("after_accept_last", s, 32'h001E0000);
      chk("overrun_sticky", 32'(overrun), 32'h1);

      // Trigger beats stop in the same cycle; stop alone silences
      set_voice(1, 100, 3);
      pulse(2'b10, '0);
      wait_sample(s, b, cyc);
      chk("ts_first", s, 32'h000A0000);
      pulse(2'b10, 2'b10);
      chk("ts_busy", 32'(busy), 32'h2);
      wait_sample(s, b, cyc);
      chk("ts_restart", s, 32'h000A0000);
      pulse('0, 2'b10);
      chk("stop_busy", 32'(busy), 32'h0);
      wait_sample(s, b, cyc);
      chk("stop_silent", s, 32'h0);

`ifdef SFX_LOOP_EN
      set_voice(0, 400, 2);
      loop_en = 2'b01;
      pulse(2'b01, '0);
      for (int i = 0; i < 4; i++) begin
         wait_sample(s, b, cyc);
         chk($sformatf("loop%0d", i), s, (i % 2 == 0) ? 32'h00050000 : 32'h00060000);
         chk($sformatf("loop%0d_busy", i), 32'(b), 32'h1);
      end
      pulse('0, 2'b01);
      wait_sample(s, b, cyc);
      chk("loop_stopped", s, 32'h0);
      chk("loop_stopped_busy", 32'(b), 32'h0);
      loop_en = '0;
`endif

      // Asynchronous reset while a sample is pending
      set_voice(0, 100, 3);
      pulse(2'b01, '0);
      sample_ready = 1'b0;
      wait_valid(cyc);
      #3 KEY = 1'b0;
      #1;
      chk("arst_valid", 32'(sample_valid), 32'h0);
      chk("arst_sample", sample_out, 32'h0);
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_overrun", 32'(overrun), 32'h0);
      sample_ready = 1'b1;
      @(negedge CLOCK_50);
      KEY = 1'b1;
      wait_sample(s, b, cyc);
      chk("arst_relatency", 32'(cyc), 32'd20);
      chk("arst_silent", s, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sfx_player.md
# sfx_player

Multi-voice sound-effect player for the game audio path. Each voice plays a fixed-length clip from a shared sample ROM at a programmable sample rate. Voices are mixed with saturation, and one sample per sample period is presented to the audio controller over a valid/ready handshake. It generalises the single-clip, single-enable playback block to N independently triggered voices, with an end-of-clip stop.

## Interface
Parameters:
- NUM_VOICES, 2: number of independent voices (1..8).
- SAMPLE_W, 16: signed ROM sample width.
- ADDR_W, 15: ROM address width.
- OUT_W, 32: audio controller sample width. The mixed sample is left-aligned by shifting it left by OUT_W-SAMPLE_W.
- CLK_DIV, 6250: CLOCK_50 cycles per sample period (8 kHz). Must be at least 2*NUM_VOICES+4.

Ports:
- CLOCK_50  in  1  system clock; the only clock.
- KEY  in  1  reset, asynchronous, active-low.
- trigger  in  NUM_VOICES  one-cycle pulse per voice; starts or restarts that voice at its clip start.
- stop  in  NUM_VOICES  one-cycle pulse per voice; silences that voice.
- voice_base  in  NUM_VOICES*ADDR_W  packed clip start address per voice.
- voice_len  in  NUM_VOICES*ADDR_W  packed clip length in samples per voice.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_q  in  SAMPLE_W  ROM data, valid one cycle after rom_addr.
- sample_out  out  OUT_W  mixed, left-aligned sample.
- sample_valid  out  1  sample_out holds a new sample.
- sample_ready  in  1  controller accepts the sample (audio_out_allowed).
- busy  out  NUM_VOICES  the voice is playing.
- overrun  out  1  sticky flag: a sample tick was dropped.

## Operation
- Reset state: every voice inactive, every position 0, tick counter 0, FSM in IDLE. All outputs are 0.
- Tick counter:
  - Counts 0..CLK_DIV-1 and wraps.
  - A tick is generated when the count equals CLK_DIV-1.
- FSM states: IDLE, READ, ACC, PRESENT.
  - IDLE: on a tick, clear the accumulator, set v=0, go to READ.
  - READ: rom_addr <= base[v] + pos[v], truncated to ADDR_W. Go to ACC.
  - ACC:
    - If busy[v], add the sign-extended rom_q to the accumulator and advance pos[v].
    - If v < NUM_VOICES-1, increment v and go to READ; otherwise go to PRESENT.
  - PRESENT:
    - Saturate the accumulator to signed SAMPLE_W, shift it left by OUT_W-SAMPLE_W, and register it on sample_out.
    - Hold sample_valid high until the cycle in which sample_ready is high, then return to IDLE.
    - sample_out is stable while sample_valid is high.
- Accumulator width is SAMPLE_W + clog2(NUM_VOICES) + 1, signed. Inactive voices contribute 0.
- Voice advance: if pos == len-1, the voice ends (busy=0, pos=0); otherwise pos increments.
- trigger[v]:
  - Sets busy=1 and pos=0 in the next cycle, in any FSM state.
  - Takes priority over an advance or stop in the same cycle.
  - Ignored when len[v]==0.
- stop[v] clears busy immediately. The voice contributes 0 from its next ACC.
- A tick that arrives outside IDLE is dropped and sets overrun. overrun clears only on reset.
- Reset asserted mid-operation returns everything to the reset state asynchronously. No partial sample is emitted.

## Timing
- Tick to sample_valid rising: 2*NUM_VOICES+1 cycles (5 with the default parameters).
- sample_valid falls in the cycle after the accept cycle.
- Back-to-back samples are at least CLK_DIV cycles apart.
- A trigger pulse at least 2*NUM_VOICES+2 cycles before a tick guarantees that the voice's first sample (pos 0) appears in that tick's output.
- ROM latency is fixed at 1 cycle. A deeper ROM pipeline is not supported.

## Configuration
- SFX_LOOP_EN defined:
  - Adds input loop_en [NUM_VOICES].
  - A voice with loop_en set wraps pos from len-1 to 0 and stays busy until it receives stop.
- SFX_LOOP_EN undefined:
  - The loop_en port is absent.
  - Every voice is one-shot and ends after its last sample.

## Structure
- Package sfx_pkg:
  - FSM state enum (IDLE/READ/ACC/PRESENT).
  - Saturation helper function.
  - Default CLK_DIV constant.
- Sub-module sfx_voice, instantiated NUM_VOICES times with generate:
  - Holds pos, busy and the trigger/stop/advance/loop priority logic.
  - Exports pos and busy.
- The top level holds the tick counter, FSM, accumulator and output register.

## Test plan
- Reset release, no triggers, CLK_DIV=16: a sample_valid every 16 cycles with sample_out=0; busy=0; overrun=0.
- Voice 0 with base=100, len=3, ROM[100..102]=10,20,30: three samples with 10<<16, 20<<16, 30<<16, then 0s; busy[0] falls after the third.
- Both voices playing 0x7000 each: sample_out=0x7FFF<<16 (saturated). With -0x7000 each: sample_out=0x8000<<16.
- sample_ready held low for 40 cycles with CLK_DIV=16: sample_out stays stable, overrun=1, and the next sample follows the accept.
- trigger and stop on voice 1 in the same cycle mid-clip: busy[1]=1 and pos restarts at 0. A trigger with len=0 leaves busy=0.
- SFX_LOOP_EN with loop_en[0]=1, len=2, ROM=5,6: output is 5,6,5,6… until stop, then 0.
